i2c_slave: RTL and testbench
============================

# i2c_slave

I2C target (slave) controller that connects a system-clocked host interface to an open-drain I2C bus. It detects START/STOP, matches a 7-bit address, and ACKs. It receives bytes into `data_read` and transmits bytes from `data_write`. SCL and SDA are oversampled by the system clock, which must be at least 4× the SCL rate. It sits between the bus pad logic (separate in/out lines, wired-AND externally) and the host register logic.

## Interface
- No parameters.
- `clock` in 1: system clock; all logic on rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `enable` in 1: 0 = ignore bus, release lines, force IDLE.
- `address` in 7: own bus address.
- `data_write` in 8: next byte to transmit to master.
- `data_read` out 8: last byte received from master.
- `read_write_flag` out 1: R/W bit of the current addressed transfer.
- `data_finish` out 1: one-cycle pulse per completed data byte.
- `transfer_status` out 1: high while addressed (own address matched, until STOP/START).
- `bus_status` out 1: high between any START and STOP (bus busy).
- `error` out 1: one-cycle pulse on a protocol error.
- `scl_in` in 1: bus SCL level.
- `scl_out` out 1: SCL drive; 1 = released. Constant 1, with no clock stretching.
- `sda_in` in 1: bus SDA level.
- `sda_out` out 1: SDA drive; 0 = pull low, 1 = released.

## Operation
- **Edge detection:** registers `scl_last` and `sda_last` (reset value 1).
  - SCL rise = ~scl_last & scl_in; SCL fall = scl_last & ~scl_in.
  - START = scl_in & scl_last & sda_last & ~sda_in.
  - STOP = scl_in & scl_last & ~sda_last & sda_in.
- **States:** IDLE, ADDR, ADDR_ACK, RX_DATA, RX_ACK, TX_DATA, TX_ACK, WAIT_STOP.
- **START from any state** → ADDR. Bit counter is cleared and `bus_status`=1.
- **STOP from any state** → IDLE. `bus_status`=0 and `transfer_status`=0.
- **ADDR:** sample SDA on 8 SCL rises, MSB first (7 address bits, then R/W).
  - Match → ADDR_ACK; `read_write_flag` ← R/W bit.
  - Mismatch → WAIT_STOP; SDA is never driven.
- **R/W convention for this block:**
  - R/W=1: slave receives (RX path).
  - R/W=0: slave transmits (TX path).
- **ADDR_ACK:** at the next SCL fall, drive `sda_out`=0 and set `transfer_status`=1. At the following fall, release (RX) or drive the MSB of `data_write` (TX).
- **RX_DATA:** shift SDA on each rise. After the 8th rise: update `data_read`, pulse `data_finish`, go to RX_ACK. Drive ACK from the next fall to the fall after it, then return to RX_DATA.
- **TX_DATA:** drive the next bit on each SCL fall; the last bit is held until the fall after the 8th rise. Then release SDA and go to TX_ACK.
- **TX_ACK:** sample master ACK on the rise and pulse `data_finish`.
  - ACK (0): reload the shift register from `data_write` at the next fall, drive its MSB, go to TX_DATA.
  - NACK: go to WAIT_STOP.
- **`error` pulse:** START or STOP detected while the bit counter is nonzero, in ADDR, RX_DATA or TX_DATA. The START/STOP is still honoured.
- **`enable`=0:** IDLE, `sda_out`=1, status outputs 0; `data_read` is held.

## Timing
- **Reset values:** `sda_out`=1, `scl_out`=1, `data_read`=0, all flags 0, state IDLE.
- **`sda_out` changes** on the clock edge where the SCL fall is detected, i.e. one clock after SCL goes low. It never changes while SCL is high.
- **`data_read` and `data_finish`** are valid on the clock after the 8th-bit rise is detected.
- **`data_write` requirement:** must be stable from the TX_ACK `data_finish` pulse until the next SCL fall (≥1 clock). The first byte must be stable by the fall that ends ADDR_ACK.
- **Simultaneous events:** START/STOP take priority over edge-based bit handling in the same cycle.

## Configuration
- **`I2C_SLAVE_GENERAL_CALL_EN` defined:** address 0x00 with R/W=1 also matches. It is ACKed and received like an own-address write, with `read_write_flag`=1.
- **Undefined:** 0x00 is treated as a mismatch.

## Structure
- **Shared package:** state enum, R/W encoding constants, general-call address constant.
- **Sub-module `i2c_bus_monitor`:** SCL/SDA edge registers plus START/STOP/rise/fall strobes; `bus_status` derives from it.
- **Top-level:** FSM, shift register, bit counter.

## Test plan
- **Wrong address:** SCL = 4 clocks, START, 0xC9, STOP → `sda_out` stays 1 throughout; `transfer_status` stays 0; `bus_status` is 1 only between START and STOP.
- **Receive:** address 0x5D with R/W=1, bytes 13 57 9B DF, STOP → ACK low on all 5 ninth clocks; `data_read` shows 0x13, 0x57, 0x9B, 0xDF in order; exactly 4 `data_finish` pulses.
- **Transmit:** address 0x5D with R/W=0, `data_write` sequence 13 57 9B DF, master ACKs, final NACK, STOP → bits sampled at SCL rises equal each byte MSB first; SDA is released after the NACK.
- **Repeated START mid-byte** (after 3 data bits) → one `error` pulse; re-addressing succeeds.
- **Disable / reset mid-transfer:** `enable`=0 or `reset` pulse during RX → `sda_out`=1 at once, IDLE; the next START/address is handled normally.
- **General call 0x00** (R/W=1) → ACKed only when `I2C_SLAVE_GENERAL_CALL_EN` is defined.

Source files
------------

// File: rtl/i2c_slave_pkg.sv
// i2c_slave_pkg: shared FSM state encoding and bus constants for the I2C target
`timescale 1ns/1ps
package i2c_slave_pkg;
  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, RX_DATA, RX_ACK, TX_DATA, TX_ACK, WAIT_STOP
  } state_t;
  localparam logic       RW_RX      = 1'b1;
  localparam logic       RW_TX      = 1'b0;
  localparam logic [6:0] GCALL_ADDR = 7'h00;
endpackage

// File: rtl/i2c_bus_monitor.sv
// i2c_bus_monitor: oversampled SCL/SDA edge registers, START/STOP/rise/fall strobes and bus-busy flag
`timescale 1ns/1ps
module i2c_bus_monitor (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop,
  output logic bus_status
);
  logic scl_last, sda_last;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      scl_last   <= 1'b1;
      sda_last   <= 1'b1;
      bus_status <= 1'b0;
    end else begin
      scl_last   <= scl_in;
      sda_last   <= sda_in;
      bus_status <= !enable ? 1'b0 : start ? 1'b1 : stop ? 1'b0 : bus_status;
    end
  assign scl_rise = ~scl_last & scl_in;
  assign scl_fall = scl_last & ~scl_in;
  assign start    = scl_in & scl_last & sda_last & ~sda_in;
  assign stop     = scl_in & scl_last & ~sda_last & sda_in;
endmodule

// File: rtl/i2c_slave.sv
// i2c_slave: I2C target FSM with address match, byte RX/TX and ACK handling.
// Define I2C_SLAVE_GENERAL_CALL_EN to also accept the general-call address 0x00 as a write.
`timescale 1ns/1ps
module i2c_slave import i2c_slave_pkg::*; (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [6:0] address,
  input  logic [7:0] data_write,
  output logic [7:0] data_read,
  output logic       read_write_flag,
  output logic       data_finish,
  output logic       transfer_status,
  output logic       bus_status,
  output logic       error,
  input  logic       scl_in,
  output logic       scl_out,
  input  logic       sda_in,
  output logic       sda_out
);
  state_t     state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [7:0] shreg, shreg_n, data_read_n, rx_byte;
  logic       rw_n, fin_n, ts_n, err_n, sda_n;
  logic       scl_rise, scl_fall, start, stop, own_match, gcall, mid_byte;

  i2c_bus_monitor u_mon (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .scl_in     (scl_in),
    .sda_in     (sda_in),
    .scl_rise   (scl_rise),
    .scl_fall   (scl_fall),
    .start      (start),
    .stop       (stop),
    .bus_status (bus_status)
  );

  assign scl_out   = 1'b1;
  assign rx_byte   = {shreg[6:0], sda_in};
  assign own_match = rx_byte[7:1] == address;
`ifdef I2C_SLAVE_GENERAL_CALL_EN
  assign gcall = rx_byte == {GCALL_ADDR, RW_RX};
`else
  assign gcall = 1'b0;
`endif
  // The SCL high phase carrying a START/STOP is itself counted as a rise, so one counted bit is not a broken byte
  assign mid_byte = cnt > 4'd1 && (state == ADDR || state == RX_DATA || state == TX_DATA);

  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state           <= IDLE;
      cnt             <= '0;
      shreg           <= '0;
      data_read       <= '0;
      read_write_flag <= 1'b0;
      data_finish     <= 1'b0;
      transfer_status <= 1'b0;
      error           <= 1'b0;
      sda_out         <= 1'b1;
    end else begin
      state           <= state_n;
      cnt             <= cnt_n;
      shreg           <= shreg_n;
      data_read       <= data_read_n;
      read_write_flag <= rw_n;
      data_finish     <= fin_n;
      transfer_status <= ts_n;
      error           <= err_n;
      sda_out         <= sda_n;
    end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    shreg_n     = shreg;
    data_read_n = data_read;
    rw_n        = read_write_flag;
    fin_n       = 1'b0;
    err_n       = 1'b0;
    ts_n        = transfer_status;
    sda_n       = sda_out;
    if (!enable) begin
      state_n = IDLE;
      cnt_n   = '0;
      rw_n    = 1'b0;
      ts_n    = 1'b0;
      sda_n   = 1'b1;
    end else if (start || stop) begin
      state_n = start ? ADDR : IDLE;
      cnt_n   = '0;
      ts_n    = 1'b0;
      sda_n   = 1'b1;
      err_n   = mid_byte;
    end else begin
      case (state)
        ADDR: if (scl_rise) begin
          shreg_n = rx_byte;
          cnt_n   = cnt + 4'd1;
          if (cnt == 4'd7) begin
            cnt_n   = '0;
            state_n = (own_match || gcall) ? ADDR_ACK : WAIT_STOP;
            rw_n    = (own_match || gcall) ? rx_byte[0] : read_write_flag;
          end
        end
        // sda_out low marks that the ACK slot has already started
        ADDR_ACK: if (scl_fall) begin
          if (sda_out) begin
            sda_n = 1'b0;
            ts_n  = 1'b1;
          end else if (read_write_flag == RW_RX) begin
            sda_n   = 1'b1;
            state_n = RX_DATA;
          end else begin
            {sda_n, shreg_n} = {data_write, 1'b0};
            state_n          = TX_DATA;
          end
        end
        RX_DATA: if (scl_rise) begin
          shreg_n = rx_byte;
          cnt_n   = cnt + 4'd1;
          if (cnt == 4'd7) begin
            cnt_n       = '0;
            data_read_n = rx_byte;
            fin_n       = 1'b1;
            state_n     = RX_ACK;
          end
        end
        RX_ACK: if (scl_fall) begin
          sda_n   = !sda_out;
          state_n = sda_out ? RX_ACK : RX_DATA;
        end
        // shreg holds the not-yet-driven bits MSB-aligned; the bit on the wire lives in sda_out
        TX_DATA: if (scl_rise) cnt_n = cnt + 4'd1;
        else if (scl_fall) begin
          if (cnt == 4'd8) begin
            sda_n   = 1'b1;
            cnt_n   = '0;
            state_n = TX_ACK;
          end else {sda_n, shreg_n} = {shreg, 1'b0};
        end
        TX_ACK: if (scl_rise) begin
          fin_n   = 1'b1;
          state_n = sda_in ? WAIT_STOP : TX_ACK;
          cnt_n   = sda_in ? 4'd0 : 4'd1;
        end else if (scl_fall && cnt == 4'd1) begin
          {sda_n, shreg_n} = {data_write, 1'b0};
          cnt_n            = '0;
          state_n          = TX_DATA;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_i2c_slave.sv
// tb_i2c_slave: table-driven and randomized I2C master transactions checked against a transaction-level model
`timescale 1ns/1ps
module tb_i2c_slave;
`ifdef I2C_SLAVE_GENERAL_CALL_EN
  localparam bit GC_EN = 1'b1;
`else
  localparam bit GC_EN = 1'b0;
`endif

  logic       clock = 1'b0, reset = 1'b1, enable = 1'b0;
  logic [6:0] address = 7'h5D;
  logic [7:0] data_write = 8'h00;
  logic [7:0] data_read;
  logic       read_write_flag, data_finish, transfer_status, bus_status, error;
  logic       scl_in, scl_out, sda_in, sda_out;
  logic       m_scl = 1'b1, m_sda = 1'b1;

  assign scl_in = m_scl;
  assign sda_in = m_sda & sda_out;

  i2c_slave dut (
    .clock           (clock),
    .reset           (reset),
    .enable          (enable),
    .address         (address),
    .data_write      (data_write),
    .data_read       (data_read),
    .read_write_flag (read_write_flag),
    .data_finish     (data_finish),
    .transfer_status (transfer_status),
    .bus_status      (bus_status),
    .error           (error),
    .scl_in          (scl_in),
    .scl_out         (scl_out),
    .sda_in          (sda_in),
    .sda_out         (sda_out)
  );

  always #5 clock = ~clock;

  int         tests = 0, fails = 0, q = 2;
  int         fin_cnt = 0, err_cnt = 0, drove_cnt = 0, hi_glitch = 0;
  logic [7:0] rx_q[$];
  logic       prev_sda = 1'b1;

  always @(posedge clock) begin
    #1;
    if (!reset && enable) begin
      if (data_finish) begin
        fin_cnt++;
        rx_q.push_back(data_read);
      end
      if (error) err_cnt++;
      if (!sda_out) drove_cnt++;
      if (sda_out != prev_sda && scl_in) hi_glitch++;
    end
    prev_sda = sda_out;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish, required finish within time limit");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", nm, got, exp);
    end
  endtask

  function automatic logic model_ack(input logic [7:0] ab, input logic [6:0] own);
    return ab[7:1] == own || (GC_EN && ab == 8'h01);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic m_start;
    tick(q); m_sda = 1'b1;
    tick(q); m_scl = 1'b1;
    tick(q); m_sda = 1'b0;
    tick(q); m_scl = 1'b0;
    tick(q);
  endtask

  task automatic m_stop;
    tick(q); m_sda = 1'b0;
    tick(q); m_scl = 1'b1;
    tick(q); m_sda = 1'b1;
    tick(q);
  endtask

  task automatic m_bit(input logic b, output logic s);
    tick(q); m_sda = b;
    tick(q); m_scl = 1'b1;
    tick(q); s = sda_in;
    tick(q); m_scl = 1'b0;
  endtask

  task automatic m_wbyte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) m_bit(b[i], s);
    m_bit(1'b1, ack);
  endtask

  task automatic xfer(input logic [7:0] ab, input int n, input logic [31:0] d,
                      output logic ack, output logic rwf, output logic ts, output logic bs,
                      output logic nack_seen, output logic [31:0] txd);
    logic s;
    logic [7:0] b;
    txd = '0;
    nack_seen = 1'b0;
    data_write = d[31:24];
    m_start;
    bs = bus_status;
    m_wbyte(ab, ack);
    rwf = read_write_flag;
    ts = transfer_status;
    for (int k = 0; k < n && !ack; k++) begin
      b = d[31-8*k -: 8];
      if (ab[0]) begin
        m_wbyte(b, s);
        nack_seen |= s;
      end else begin
        for (int i = 7; i >= 0; i--) begin
          m_bit(1'b1, s);
          b[i] = s;
        end
        txd = {txd[23:0], b};
        if (k < 3) data_write = d[23-8*k -: 8];
        m_bit(k == n - 1, s);
      end
    end
    m_stop;
  endtask

  task automatic run_and_check(input string nm, input logic [7:0] ab, input int n,
                               input logic [31:0] d, input logic exp_nack, input int exp_fin);
    logic ack, rwf, ts, bs, nk;
    logic [31:0] txd, rxd, exp_d;
    int f0, e0, dr0, q0;
    f0 = fin_cnt; e0 = err_cnt; dr0 = drove_cnt; q0 = rx_q.size();
    xfer(ab, n, d, ack, rwf, ts, bs, nk, txd);
    tick(1);
    exp_d = d >> (8 * (4 - n));
    chk({nm, " addr_ack"}, 32'(ack), 32'(exp_nack));
    chk({nm, " finish_cnt"}, 32'(fin_cnt - f0), 32'(exp_fin));
    chk({nm, " sda_driven"}, 32'(drove_cnt != dr0), 32'(!exp_nack));
    chk({nm, " error_cnt"}, 32'(err_cnt - e0), 32'd0);
    chk({nm, " bus_busy"}, 32'(bs), 32'd1);
    chk({nm, " bus_idle"}, 32'(bus_status), 32'd0);
    chk({nm, " ts_after_stop"}, 32'(transfer_status), 32'd0);
    chk({nm, " sda_released"}, 32'(sda_out), 32'd1);
    if (!exp_nack) begin
      chk({nm, " rw_flag"}, 32'(rwf), 32'(ab[0]));
      chk({nm, " ts_during"}, 32'(ts), 32'd1);
      if (ab[0]) begin
        rxd = '0;
        for (int i = q0; i < rx_q.size(); i++) rxd = {rxd[23:0], rx_q[i]};
        chk({nm, " rx_data"}, rxd, exp_d);
        chk({nm, " rx_acks"}, 32'(nk), 32'd0);
      end else chk({nm, " tx_data"}, txd, exp_d);
    end
  endtask

  typedef struct {
    string       name;
    logic [7:0]  ab;
    int          n;
    logic [31:0] d;
    logic        exp_nack;
    int          exp_fin;
    int          q;
  } vec_t;
  vec_t tbl[8];

  initial begin
    logic       ack, s, exp_nack;
    logic [6:0] own;
    logic [7:0] ab, b;
    logic [31:0] d;
    int         e0, q0, n;
    tbl[0] = '{"wrong_addr", 8'hC9, 1, 32'hAA000000, 1'b1, 0, 1};
    tbl[1] = '{"rx4",        8'hBB, 4, 32'h13579BDF, 1'b0, 4, 2};
    tbl[2] = '{"tx4",        8'hBA, 4, 32'h13579BDF, 1'b0, 4, 2};
    tbl[3] = '{"gcall",      8'h01, 2, 32'hA53C0000, !GC_EN, GC_EN ? 2 : 0, 2};
    tbl[4] = '{"wrong_tx",   8'h5C, 1, 32'h11000000, 1'b1, 0, 3};
    tbl[5] = '{"rx1_zero",   8'hBB, 1, 32'h00000000, 1'b0, 1, 1};
    tbl[6] = '{"tx1_ones",   8'hBA, 1, 32'hFF000000, 1'b0, 1, 3};
    tbl[7] = '{"tx2_edge",   8'hBA, 2, 32'h00810000, 1'b0, 2, 1};

    tick(3);
    chk("reset sda_out", 32'(sda_out), 32'd1);
    chk("reset scl_out", 32'(scl_out), 32'd1);
    chk("reset data_read", 32'(data_read), 32'd0);
    chk("reset rw_flag", 32'(read_write_flag), 32'd0);
    chk("reset data_finish", 32'(data_finish), 32'd0);
    chk("reset transfer_status", 32'(transfer_status), 32'd0);
    chk("reset bus_status", 32'(bus_status), 32'd0);
    chk("reset error", 32'(error), 32'd0);
    reset = 1'b0;
    tick(1);
    enable = 1'b1;
    tick(2);

    address = 7'h5D;
    foreach (tbl[i]) begin
      q = tbl[i].q;
      run_and_check(tbl[i].name, tbl[i].ab, tbl[i].n, tbl[i].d, tbl[i].exp_nack, tbl[i].exp_fin);
    end

    // repeated START three bits into a received byte
    q = 2;
    e0 = err_cnt;
    m_start;
    m_wbyte(8'hBB, ack);
    chk("rs first_ack", 32'(ack), 32'd0);
    for (int i = 0; i < 3; i++) m_bit(i == 1, s);
    m_start;
    chk("rs error_pulse", 32'(err_cnt - e0), 32'd1);
    chk("rs ts_cleared", 32'(transfer_status), 32'd0);
    chk("rs bus_busy", 32'(bus_status), 32'd1);
    q0 = rx_q.size();
    m_wbyte(8'hBB, ack);
    chk("rs readdr_ack", 32'(ack), 32'd0);
    m_wbyte(8'h6E, ack);
    chk("rs data_ack", 32'(ack), 32'd0);
    m_stop;
    tick(1);
    chk("rs rx_count", 32'(rx_q.size() - q0), 32'd1);
    if (rx_q.size() > q0) chk("rs rx_data", 32'(rx_q[q0]), 32'h6E);
    chk("rs error_total", 32'(err_cnt - e0), 32'd1);

    // disable while the slave holds the data ACK low
    m_start;
    m_wbyte(8'hBB, ack);
    chk("dis addr_ack", 32'(ack), 32'd0);
    b = 8'hC4;
    for (int i = 7; i >= 0; i--) m_bit(b[i], s);
    tick(1);
    chk("dis ack_driven", 32'(sda_out), 32'd0);
    enable = 1'b0;
    tick(1);
    chk("dis sda_released", 32'(sda_out), 32'd1);
    chk("dis ts", 32'(transfer_status), 32'd0);
    chk("dis bus_status", 32'(bus_status), 32'd0);
    chk("dis data_read_held", 32'(data_read), 32'hC4);
    enable = 1'b1;
    tick(2);
    run_and_check("after_disable", 8'hBB, 1, 32'h5A000000, 1'b0, 1);

    // asynchronous reset while the slave holds the data ACK low
    m_start;
    m_wbyte(8'hBB, ack);
    b = 8'h81;
    for (int i = 7; i >= 0; i--) m_bit(b[i], s);
    tick(1);
    chk("rst ack_driven", 32'(sda_out), 32'd0);
    #1 reset = 1'b1;
    #1;
    chk("rst sda_async", 32'(sda_out), 32'd1);
    chk("rst data_read", 32'(data_read), 32'd0);
    chk("rst ts", 32'(transfer_status), 32'd0);
    tick(2);
    reset = 1'b0;
    tick(2);
    run_and_check("after_reset", 8'hBA, 2, 32'h3CC30000, 1'b0, 2);

    for (int t = 0; t < 30; t++) begin
      own = 7'($urandom_range(1, 127));
      address = own;
      q = $urandom_range(1, 3);
      n = $urandom_range(1, 4);
      d = $urandom;
      ab = ($urandom_range(0, 3) != 0) ? {own, 1'($urandom_range(0, 1))} : 8'($urandom);
      exp_nack = !model_ack(ab, own);
      run_and_check($sformatf("rand%0d", t), ab, n, d, exp_nack, exp_nack ? 0 : n);
    end

    chk("sda_stable_while_scl_high", 32'(hi_glitch), 32'd0);
    chk("scl_never_stretched", 32'(scl_out), 32'd1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
